// File: rtl/sqrt_vec_sequencer.sv
// sqrt_vec_sequencer: feeds active fp16 lanes one at a time to a scalar sqrt unit and returns the result vector.
module sqrt_vec_sequencer #(
   parameter int LANES   = 4,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    vec_valid_in,
   output logic                    vec_ready_out,
   input  logic [LANES*DATA_W-1:0] vec_operand,
   input  logic [LANES-1:0]        vec_mask,
   output logic                    vec_valid_out,
   input  logic                    vec_ready_in,
   output logic [LANES*DATA_W-1:0] vec_result,
   output logic                    timeout_err,
   output logic [DATA_W-1:0]       sq_operand,
   output logic                    sq_valid_in,
   output logic                    sq_ready_out,
   input  logic                    sq_ready_in,
   input  logic                    sq_valid_out,
   input  logic [DATA_W-1:0]       sq_result
);
   localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [DATA_W-1:0] QNAN = DATA_W'(16'h7E00);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, state_nxt;
   logic [LANES*DATA_W-1:0] op_r, res_r;
   logic [LANES-1:0] mask_r;
   logic [PW-1:0] ptr, first_ptr, nxt_ptr;
   logic [WW-1:0] wdog;
   logic has_nxt, wd_fire, lane_done;
   always_comb begin
      first_ptr = '0;
      nxt_ptr = '0;
      has_nxt = 1'b0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (vec_mask[i]) first_ptr = PW'(i);
         if (mask_r[i] && i > int'(ptr)) begin
            nxt_ptr = PW'(i);
            has_nxt = 1'b1;
         end
      end
   end
   // a lane completes on a real result or when the watchdog gives up on it
   assign wd_fire = (wdog == WW'(TIMEOUT - 1));
   assign lane_done = (state == WAIT) && (sq_valid_out || wd_fire);
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (vec_valid_in) state_nxt = (|vec_mask) ? ISSUE : DONE;
         ISSUE:   if (sq_ready_in) state_nxt = WAIT;
         WAIT:    if (lane_done) state_nxt = has_nxt ? ISSUE : DONE;
         DONE:    if (vec_ready_in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_r <= '0;
         mask_r <= '0;
         res_r <= '0;
         ptr <= '0;
         wdog <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE && vec_valid_in) begin
            op_r <= vec_operand;
            mask_r <= vec_mask;
            res_r <= '0;
            ptr <= first_ptr;
         end
         if (state == ISSUE) wdog <= '0;
         else if (state == WAIT) wdog <= wdog + WW'(1);
         if (lane_done) begin
            res_r[ptr*DATA_W +: DATA_W] <= sq_valid_out ? sq_result : QNAN;
            ptr <= nxt_ptr;
            if (!sq_valid_out) timeout_err <= 1'b1;
         end
      end
   end
   assign vec_ready_out = (state == IDLE);
   assign vec_valid_out = (state == DONE);
   assign vec_result = res_r;
   assign sq_ready_out = (state == WAIT);
   assign sq_valid_in = (state == ISSUE) && sq_ready_in;
   assign sq_operand = (state == ISSUE) ? op_r[ptr*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_sqrt_vec_sequencer.sv
// tb_sqrt_vec_sequencer: randomized bench with a behavioural sqrt stub and a lane-level reference model.
module tb_sqrt_vec_sequencer;
   localparam int LANES = 4;
   localparam int DW = 16;
   localparam int TO = 8;
   localparam logic [63:0] OPV = 64'h4C00_4880_4400_3C00;
   logic CLK, RST;
   logic vec_valid_in, vec_ready_out, vec_valid_out, vec_ready_in, timeout_err;
   logic [LANES*DW-1:0] vec_operand, vec_result;
   logic [LANES-1:0] vec_mask;
   logic [DW-1:0] sq_operand, sq_result;
   logic sq_valid_in, sq_ready_out, sq_ready_in, sq_valid_out;
   int tests = 0, fails = 0, issue_cnt = 0;
   bit hang = 0, force_nr = 0;

   sqrt_vec_sequencer #(.LANES(LANES), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST),
      .vec_valid_in(vec_valid_in), .vec_ready_out(vec_ready_out),
      .vec_operand(vec_operand), .vec_mask(vec_mask),
      .vec_valid_out(vec_valid_out), .vec_ready_in(vec_ready_in),
      .vec_result(vec_result), .timeout_err(timeout_err),
      .sq_operand(sq_operand), .sq_valid_in(sq_valid_in), .sq_ready_out(sq_ready_out),
      .sq_ready_in(sq_ready_in), .sq_valid_out(sq_valid_out), .sq_result(sq_result)
   );

   initial CLK = 0;
   always #5 CLK = ~CLK;

   function automatic logic [15:0] sq_fn(input logic [15:0] x);
      case (x)
         16'h3C00: return 16'h3C00;
         16'h4400: return 16'h4000;
         16'h4880: return 16'h4200;
         16'h4C00: return 16'h4400;
         default:  return {x[7:0], x[15:8]} ^ 16'h5A3C;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic expired(input string name);
      tests++;
      fails++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // scalar sqrt stub: random accept/latency, stray result pulses while idle, optional hang
   initial begin
      logic busy, hs;
      logic [15:0] cur, hs_op;
      int lat;
      busy = 0; hs = 0; cur = 0; hs_op = 0; lat = 0;
      sq_valid_out = 0; sq_ready_in = 0; sq_result = 0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            busy = 0;
            sq_valid_out = 0;
            sq_ready_in = 0;
         end else begin
            sq_valid_out = 0;
            if (hs) begin
               busy = 1;
               cur = hs_op;
               lat = $urandom_range(0, 5);
               issue_cnt++;
            end
            if (busy && !hang) begin
               if (lat == 0) begin
                  sq_valid_out = 1;
                  sq_result = sq_fn(cur);
                  busy = 0;
               end else lat--;
            end else if (!busy && $urandom_range(0, 7) == 0) begin
               sq_valid_out = 1;
               sq_result = 16'($urandom);
            end
            sq_ready_in = !force_nr && ($urandom_range(0, 3) != 0);
         end
         #1;
         hs = !RST && sq_valid_in && sq_ready_in;
         hs_op = sq_operand;
      end
   end

   // reference model: tracks the vector at lane granularity and checks every cycle
   initial begin
      bit holding, waiting, eerr;
      int remaining, wcnt, cur_lane;
      int lq[$];
      logic [63:0] eop, eres;
      logic evin;
      holding = 0; waiting = 0; eerr = 0; remaining = 0; wcnt = 0; cur_lane = 0;
      eop = 0; eres = 0;
      forever begin
         @(negedge CLK);
         #2;
         if (RST) begin
            holding = 0; waiting = 0; remaining = 0; eerr = 0;
            lq.delete();
            continue;
         end
         evin = holding && !waiting && remaining > 0 && sq_ready_in;
         chk("vec_ready_out", vec_ready_out, !holding);
         chk("vec_valid_out", vec_valid_out, holding && !waiting && remaining == 0);
         chk("sq_ready_out", sq_ready_out, waiting);
         chk("sq_valid_in", sq_valid_in, evin);
         chk("timeout_err", timeout_err, eerr);
         if (evin) chk("sq_operand", sq_operand, eop[lq[0]*16 +: 16]);
         if (holding && !waiting && remaining == 0) chk("vec_result", vec_result, eres);
         if (!holding) begin
            if (vec_valid_in) begin
               holding = 1;
               eop = vec_operand;
               eres = '0;
               lq.delete();
               for (int i = 0; i < LANES; i++)
                  if (vec_mask[i]) begin
                     lq.push_back(i);
                     eres[i*16 +: 16] = sq_fn(vec_operand[i*16 +: 16]);
                  end
               remaining = lq.size();
            end
         end else if (waiting) begin
            wcnt++;
            if (sq_valid_out) begin
               remaining--;
               waiting = 0;
            end else if (wcnt == TO) begin
               eres[cur_lane*16 +: 16] = 16'h7E00;
               eerr = 1;
               remaining--;
               waiting = 0;
            end
         end else if (remaining > 0) begin
            if (sq_ready_in) begin
               waiting = 1;
               wcnt = 0;
               cur_lane = lq.pop_front();
            end
         end else if (vec_ready_in) holding = 0;
      end
   end

   task automatic send(input logic [63:0] op, input logic [3:0] m);
      int n;
      @(negedge CLK);
      vec_operand = op;
      vec_mask = m;
      vec_valid_in = 1;
      n = 0;
      while (!vec_ready_out && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (n == 100) expired("send");
      @(negedge CLK);
      vec_valid_in = 0;
   endtask

   task automatic finish_vec(input int hold, output logic [63:0] res);
      int n;
      res = '0;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!vec_valid_out && n < 300);
      if (!vec_valid_out) begin
         expired("finish_vec");
         return;
      end
      repeat (hold) @(negedge CLK);
      res = vec_result;
      vec_ready_in = 1;
      @(negedge CLK);
      vec_ready_in = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready_out"}, vec_ready_out, 1);
      chk({tag, "_valid_out"}, vec_valid_out, 0);
      chk({tag, "_sq_valid_in"}, sq_valid_in, 0);
      chk({tag, "_sq_ready_out"}, sq_ready_out, 0);
      chk({tag, "_result"}, vec_result, 0);
      chk({tag, "_sq_operand"}, sq_operand, 0);
      chk({tag, "_err"}, timeout_err, 0);
   endtask

   initial begin
      logic [63:0] r;
      int b, cnt;
      bit found;
      RST = 1;
      vec_valid_in = 0; vec_ready_in = 0; vec_operand = 0; vec_mask = 0;
      repeat (2) @(negedge CLK);
      #1;
      chk_reset_outputs("reset");
      @(negedge CLK);
      RST = 0;
      b = issue_cnt;
      send(OPV, 4'hF);
      finish_vec($urandom_range(0, 2), r);
      chk("s1_result", r, 64'h4400_4200_4000_3C00);
      chk("s1_issues", issue_cnt - b, 4);
      b = issue_cnt;
      send(OPV, 4'b0101);
      finish_vec(1, r);
      chk("s2_result", r, 64'h0000_4200_0000_3C00);
      chk("s2_issues", issue_cnt - b, 2);
      b = issue_cnt;
      send({$urandom, $urandom}, 4'b0000);
      chk("s3_latency", vec_valid_out, 1);
      finish_vec(0, r);
      chk("s3_result", r, 0);
      chk("s3_issues", issue_cnt - b, 0);
      send({$urandom, $urandom}, 4'hF);
      finish_vec(5, r);
      force_nr = 1;
      send({$urandom, $urandom}, 4'hF);
      repeat (3) begin
         @(negedge CLK);
         #3;
         chk("s4_no_issue", sq_valid_in, 0);
         chk("s4_still_issue", sq_ready_out, 0);
      end
      force_nr = 0;
      finish_vec(0, r);
      repeat (40) begin
         send({$urandom, $urandom}, 4'($urandom));
         finish_vec($urandom_range(0, 3), r);
      end
      hang = 1;
      send({$urandom, $urandom}, 4'b0001);
      cnt = 0;
      for (int k = 0; k < 60 && !timeout_err; k++) begin
         @(negedge CLK);
         #3;
         if (!timeout_err && sq_ready_out) cnt++;
      end
      chk("s5_err", timeout_err, 1);
      chk("s5_wait_cycles", cnt, TO);
      finish_vec(0, r);
      chk("s5_result", r, 64'h0000_0000_0000_7E00);
      hang = 0;
      send({$urandom, $urandom}, 4'hF);
      finish_vec(2, r);
      chk("s5_sticky", timeout_err, 1);
      @(negedge CLK);
      RST = 1;
      #1;
      chk("s5_err_cleared", timeout_err, 0);
      @(negedge CLK);
      RST = 0;
      b = issue_cnt;
      send(OPV, 4'hF);
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge CLK);
         #3;
         found = (issue_cnt - b == 2) && sq_ready_out;
      end
      if (!found) expired("s6_lane1_wait");
      RST = 1;
      #1;
      chk_reset_outputs("s6");
      repeat (2) @(negedge CLK);
      RST = 0;
      b = issue_cnt;
      send(OPV, 4'hF);
      finish_vec(1, r);
      chk("s6_result", r, 64'h4400_4200_4000_3C00);
      chk("s6_issues", issue_cnt - b, 4);
      repeat (3) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end
endmodule
